apb_master: RTL and testbench
=============================

# apb_master

APB3 initiator that converts a single-outstanding valid/ready request from the core-side load/store path into APB setup/access transfers on the peripheral bus, and returns read data and error status through a held response handshake. It is the bus-side driver for the APB slaves on the peripheral segment, such as the timer, and owns a per-transfer watchdog so a non-responding slave cannot hang the core.

## Interface
- APB_ADDR_WIDTH, 32, width of apb_paddr and req_addr
- APB_DATA_WIDTH, 32, width of all data buses
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles waited for apb_pready; 0 disables the watchdog
- Clocking and reset: one clock, apb_pclk; reset apb_preset is asynchronous and active-high.
- apb_pclk  in  1  bus clock; all state updates on the rising edge
- apb_preset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid and req_ready are both high
- req_addr  in  APB_ADDR_WIDTH  target byte address
- req_write  in  1  1 = write, 0 = read
- req_wdata  in  APB_DATA_WIDTH  write data
- rsp_valid  out  1  response present; held until rsp_ready
- rsp_ready  in  1  consumer accepts the response
- rsp_rdata  out  APB_DATA_WIDTH  read data; 0 for writes and for aborted transfers
- rsp_err  out  1  slave pslverr or watchdog abort
- apb_paddr, apb_pwrite, apb_pwdata  out  APB_ADDR_WIDTH/1/APB_DATA_WIDTH  APB address, direction and write data
- apb_psel, apb_penable  out  1/1  APB select and enable
- apb_pready, apb_prdata, apb_pslverr  in  1/APB_DATA_WIDTH/1  slave response signals

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- **IDLE:**
  - req_ready=1, psel=0, penable=0.
  - On a handshake, latch addr, write and wdata into the apb_* outputs, then go to SETUP.
- **SETUP:**
  - psel=1, penable=0, req_ready=0.
  - Unconditionally go to ACCESS.
- **ACCESS:**
  - psel=1, penable=1.
  - If apb_pready=1: capture apb_pslverr into rsp_err. Capture apb_prdata into rsp_rdata for a read; set rsp_rdata to 0 for a write. Go to RESP.
  - Else, if TIMEOUT_CYCLES≠0 and the wait counter equals TIMEOUT_CYCLES-1: abort with rsp_err=1 and rsp_rdata=0, then go to RESP.
  - Else increment the wait counter.
- **RESP:**
  - psel=0, penable=0, rsp_valid=1.
  - rsp_rdata and rsp_err are held stable.
  - When rsp_ready=1, go to IDLE. No new request is accepted while in RESP.
- The wait counter clears on entry to SETUP. Its width is $clog2(TIMEOUT_CYCLES+1), minimum 1. It never wraps, because it is compared before incrementing.
- apb_paddr, apb_pwrite and apb_pwdata stay stable from SETUP through the end of ACCESS. In IDLE and RESP they hold their last value.
- apb_pslverr and apb_prdata are ignored unless apb_pready=1 in ACCESS.
- A pready that arrives in the same cycle as the timeout limit is honoured as a normal completion, not an abort.
- Reset asserted at any point, including mid-transfer, forces IDLE immediately. The in-flight transfer is dropped and no response is produced.
- Reset values of all outputs are 0, except req_ready, which is 1 once reset deasserts.

## Timing
- Cycle 0: handshake edge.
- Cycle 1: SETUP.
- Cycle 2: first ACCESS cycle.
- rsp_valid rises at the earliest in cycle 3 (zero-wait slave). Each slave wait state adds 1 cycle.
- Watchdog abort: rsp_valid rises TIMEOUT_CYCLES+2 cycles after the handshake edge.
- Back-to-back throughput: one transfer per 4 cycles minimum. RESP→IDLE takes one edge even when rsp_ready is already high.
- req_ready is registered, i.e. derived from state only. There is no combinational path from any input to req_ready, psel or penable.

## Structure
- The state enum (apb_master_state_e) and the default timeout constant belong in the shared APB package, dti_apb_pkg, next to the existing address map defines.
- No sub-module: the watchdog counter and FSM are implemented inline.
- Target size: about 150–200 lines.

## Test plan
- **Zero-wait write:** req addr 0x04, wdata 0x3, write. Slave pready=1 in the first ACCESS cycle. Expect psel high cycles 1–2, penable high cycle 2 only, rsp_valid in cycle 3, rsp_err=0, rsp_rdata=0.
- **Read with 2 wait states:** slave returns prdata=0xDEADBEEF with pready on the 3rd ACCESS cycle. Expect paddr stable throughout, rsp_rdata=0xDEADBEEF, rsp_valid in cycle 5.
- **Slave error:** pready=1 with pslverr=1 on a read. Expect rsp_err=1 and rsp_rdata equal to the driven prdata. With pslverr=1 but pready=0 during wait cycles, the flag must not be captured.
- **Watchdog:** TIMEOUT_CYCLES=4, pready held low. Expect exactly 4 ACCESS cycles, psel dropping in cycle 6, rsp_err=1, rsp_rdata=0. With pready=1 exactly on the 4th ACCESS cycle, expect normal completion and rsp_err=0.
- **Response backpressure and back-to-back:**
  - Hold rsp_ready=0 for 5 cycles. Expect rsp_valid and rsp_data held and req_ready=0.
  - Then queue a second request. Expect its SETUP 2 cycles after rsp_ready is accepted.
- **Mid-transfer reset:** assert apb_preset during ACCESS. Expect psel, penable and rsp_valid to be 0 immediately, no response after reset deasserts, and req_ready=1.

Source files
------------

// File: rtl/dti_apb_pkg.sv
// Shared definitions for the peripheral-segment APB bus: the APB initiator state
// encoding and the default per-transfer watchdog limit.
package dti_apb_pkg;

  localparam int unsigned APB_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_master_state_e;

endpackage

// File: rtl/apb_master.sv
// APB3 initiator: turns one valid/ready request into an APB setup/access transfer
// and returns read data / error through a held response, with a per-transfer watchdog.
module apb_master
  import dti_apb_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_DEFAULT
) (
  input  logic                      apb_pclk,
  input  logic                      apb_preset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic                      req_write,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,
  output logic [APB_ADDR_WIDTH-1:0] apb_paddr,
  output logic                      apb_pwrite,
  output logic [APB_DATA_WIDTH-1:0] apb_pwdata,
  output logic                      apb_psel,
  output logic                      apb_penable,
  input  logic                      apb_pready,
  input  logic [APB_DATA_WIDTH-1:0] apb_prdata,
  input  logic                      apb_pslverr
);

  localparam int unsigned CNT_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W     = (CNT_W_RAW == 0) ? 1 : CNT_W_RAW;
  localparam bit          WDOG_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  apb_master_state_e state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic              abort;

  always_ff @(posedge apb_pclk or posedge apb_preset) begin
    if (apb_preset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake outputs are decoded from state alone so no input reaches them combinationally.
  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    apb_psel    = 1'b0;
    apb_penable = 1'b0;
    rsp_valid   = 1'b0;
    abort       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = SETUP;
      end
      SETUP: begin
        apb_psel  = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        apb_psel    = 1'b1;
        apb_penable = 1'b1;
        if (apb_pready) begin
          state_nxt = RESP;
        end else if (WDOG_EN && (wait_cnt == CNT_LAST)) begin
          abort     = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A late pready wins over the watchdog because it is tested first.
  always_ff @(posedge apb_pclk or posedge apb_preset) begin
    if (apb_preset) begin
      apb_paddr  <= '0;
      apb_pwrite <= 1'b0;
      apb_pwdata <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            apb_paddr  <= req_addr;
            apb_pwrite <= req_write;
            apb_pwdata <= req_wdata;
            wait_cnt   <= '0;
          end
        end
        ACCESS: begin
          if (apb_pready) begin
            rsp_err   <= apb_pslverr;
            rsp_rdata <= apb_pwrite ? '0 : apb_prdata;
          end else if (abort) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: randomized and directed transfers against a reference
// model, with an APB slave model and a response scoreboard.
module tb_apb_master;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] apb_paddr;
  logic        apb_pwrite;
  logic [31:0] apb_pwdata;
  logic        apb_psel;
  logic        apb_penable;
  logic        apb_pready;
  logic [31:0] apb_prdata;
  logic        apb_pslverr;

  apb_master #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .apb_pclk   (clk),
    .apb_preset (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .apb_paddr  (apb_paddr),
    .apb_pwrite (apb_pwrite),
    .apb_pwdata (apb_pwdata),
    .apb_psel   (apb_psel),
    .apb_penable(apb_penable),
    .apb_pready (apb_pready),
    .apb_prdata (apb_prdata),
    .apb_pslverr(apb_pslverr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          h;
    int          lat;
    int          hold;
  } exp_t;

  exp_t q[$];

  // Current transfer as seen by the slave model
  int          cur_h      = 0;
  logic [31:0] exp_addr   = '0;
  logic        exp_wr     = 1'b0;
  logic [31:0] exp_wd     = '0;
  int          sl_waits   = 0;
  logic        sl_err     = 1'b0;
  logic [31:0] sl_rdata   = '0;
  int          sl_acc_exp = -1;
  int          sl_lat     = 0;
  int          last_accept = -100;

  // Driver: presents one request, records the model's expected outcome at handshake.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input int waits, input logic err, input logic [31:0] rd,
                      input int hold, input bit push);
    exp_t e;
    int   guard;
    bit   waited;
    int   acc;
    int   lat;
    req_valid = 1'b1;
    req_addr  = addr;
    req_write = wr;
    req_wdata = wd;
    guard  = 0;
    waited = 0;
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
      waited = 1;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    // Reference model: completion after waits stall cycles unless the watchdog fires first.
    if (waits < T) begin
      acc = waits + 1;
      lat = 3 + waits;
      e.err   = err;
      e.rdata = wr ? 32'h0 : rd;
    end else begin
      acc = T;
      lat = T + 2;
      e.err   = 1'b1;
      e.rdata = 32'h0;
    end
    cur_h      = cyc;
    exp_addr   = addr;
    exp_wr     = wr;
    exp_wd     = wd;
    sl_waits   = waits;
    sl_err     = err;
    sl_rdata   = rd;
    sl_acc_exp = push ? acc : -1;
    sl_lat     = lat;
    if (waited && push) chk("b2b_setup_gap", 32'(cur_h + 1 - last_accept), 32'd2);
    e.h    = cur_h;
    e.lat  = lat;
    e.hold = hold;
    if (push) q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_write = 1'($urandom_range(0, 1));
    req_wdata = $urandom;
  endtask

  // Slave model: stalls for sl_waits ACCESS cycles, driving junk (with pslverr=1) meanwhile.
  initial begin
    int acc_cnt;
    bit psel_q;
    acc_cnt     = 0;
    psel_q      = 0;
    apb_pready  = 1'b0;
    apb_prdata  = '0;
    apb_pslverr = 1'b0;
    forever begin
      @(negedge clk);
      if (apb_psel && !apb_penable) begin
        chk("setup_cycle", 32'(cyc - cur_h), 32'd1);
        acc_cnt = 0;
      end
      if (apb_psel) begin
        chk("paddr", apb_paddr, exp_addr);
        chk("pwrite", 32'(apb_pwrite), 32'(exp_wr));
        chk("pwdata", apb_pwdata, exp_wd);
      end
      if (apb_psel && apb_penable) begin
        if (acc_cnt == sl_waits) begin
          apb_pready  = 1'b1;
          apb_prdata  = sl_rdata;
          apb_pslverr = sl_err;
        end else begin
          apb_pready  = 1'b0;
          apb_prdata  = $urandom;
          apb_pslverr = 1'b1;
        end
        acc_cnt++;
      end else begin
        apb_pready  = 1'($urandom_range(0, 1));
        apb_prdata  = $urandom;
        apb_pslverr = 1'($urandom_range(0, 1));
      end
      if (!apb_psel && psel_q && sl_acc_exp >= 0) begin
        chk("access_cycles", 32'(acc_cnt), 32'(sl_acc_exp));
        chk("psel_fall_cycle", 32'(cyc - cur_h), 32'(sl_lat));
      end
      psel_q = apb_psel;
    end
  end

  // Monitor: pops the scoreboard on every new response and applies backpressure.
  initial begin
    exp_t e;
    bit   prev;
    prev      = 0;
    rsp_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 0;
        continue;
      end
      if (rsp_valid && !prev) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("rsp_latency", 32'(cyc - e.h), 32'(e.lat));
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("req_ready_in_resp", 32'(req_ready), 32'd0);
          chk("psel_in_resp", 32'(apb_psel), 32'd0);
          if (e.hold > 0) begin
            rsp_ready = 1'b0;
            for (int i = 0; i < e.hold; i++) begin
              @(negedge clk);
              chk("hold_valid", 32'(rsp_valid), 32'd1);
              chk("hold_rdata", rsp_rdata, e.rdata);
              chk("hold_err", 32'(rsp_err), 32'(e.err));
              chk("hold_req_ready", 32'(req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
          end
          last_accept = cyc;
        end
      end
      prev = rsp_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int guard;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_write = 1'b0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_psel", 32'(apb_psel), 32'd0);
    chk("rst_penable", 32'(apb_penable), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_paddr", apb_paddr, 32'd0);
    chk("rst_pwrite", 32'(apb_pwrite), 32'd0);
    chk("rst_pwdata", apb_pwdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_rst", 32'(req_ready), 32'd1);

    // Directed cases
    xfer(32'h0000_0004, 1'b1, 32'h3, 0, 1'b0, 32'hAAAA_5555, 0, 1);   // zero-wait write
    xfer(32'h0000_0010, 1'b0, 32'h0, 2, 1'b0, 32'hDEAD_BEEF, 0, 1);   // read, 2 waits
    xfer(32'h0000_0020, 1'b0, 32'h0, 0, 1'b1, 32'h1234_5678, 0, 1);   // slave error
    xfer(32'h0000_0024, 1'b1, 32'h55, 1, 1'b0, 32'h0, 0, 1);          // junk pslverr while waiting
    xfer(32'h0000_0030, 1'b0, 32'h0, 100, 1'b0, 32'hCAFE_F00D, 0, 1); // watchdog abort
    xfer(32'h0000_0034, 1'b0, 32'h0, T - 1, 1'b0, 32'h0BAD_CAFE, 0, 1); // pready at the limit
    xfer(32'h0000_0040, 1'b0, 32'h0, 1, 1'b0, 32'h7777_1111, 5, 1);   // backpressure
    xfer(32'h0000_0044, 1'b1, 32'h99, 0, 1'b0, 32'h0, 0, 1);          // queued behind it

    for (int i = 0; i < 40; i++) begin
      int gap;
      int hold;
      gap  = $urandom_range(0, 2);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      repeat (gap) @(negedge clk);
      xfer($urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), $urandom,
           $urandom_range(0, 6), 1'($urandom_range(0, 1)), $urandom, hold, 1);
    end

    guard = 0;
    while ((q.size() != 0 || !req_ready) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_scoreboard", 32'(q.size()), 32'd0);
    chk("drain_idle", 32'(req_ready), 32'd1);

    // Reset in the middle of an ACCESS phase
    xfer(32'h0000_0050, 1'b0, 32'h0, 100, 1'b0, 32'h0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_psel", 32'(apb_psel), 32'd0);
    chk("midrst_penable", 32'(apb_penable), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("midrst_req_ready", 32'(req_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
